// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter: loader-priority with fetch starvation guard,
// address checking and one-cycle response routing. Optional lock via IMEM_ARB_LOCK_EN.
module imem_port_arbiter #(
    parameter int          DEPTH      = 256,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] RESET_NOP  = 32'h00000013,
    localparam int         IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_err,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic             l_err,
    output logic             m_en,
    output logic             m_we,
    output logic [IDX_W-1:0] m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
`ifdef IMEM_ARB_LOCK_EN
    ,
    input  logic             l_lock
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic        lock_active;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        f_win, granted, addr_err, access;
    logic [31:0] sel_addr;

    logic        tag_valid_reg, tag_owner_reg, tag_err_reg, tag_write_reg;
    logic        f_resp, l_resp;
    logic [31:0] f_rdata_reg, f_rdata_next, l_rdata_reg, l_rdata_next;
    logic        f_err_reg, f_err_next, l_err_reg, l_err_next;

`ifdef IMEM_ARB_LOCK_EN
    assign lock_active = l_lock;
`else
    assign lock_active = 1'b0;
`endif

    // Fetch wins alone, or in a conflict once it has been starved long enough.
    assign f_win = f_req && (!l_req || (starve_cnt_reg == STARVE_LIM)) && !lock_active;
    assign f_gnt = rst_n && f_win;
    assign l_gnt = rst_n && l_req && !f_win;

    assign granted  = f_gnt || l_gnt;
    assign sel_addr = l_gnt ? l_addr : f_addr;
    assign addr_err = (sel_addr[1:0] != 2'b00) || (|sel_addr[31:IDX_W+2]);
    assign access   = granted && !addr_err;

    assign m_en    = access;
    assign m_we    = access && l_gnt && l_we;
    assign m_addr  = access ? sel_addr[IDX_W+1:2] : '0;
    assign m_wdata = access ? l_wdata : '0;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!f_req || f_gnt || lock_active)
            starve_cnt_next = 4'd0;
        else if (l_gnt && (starve_cnt_reg != STARVE_LIM))
            starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    // Read data is passed through during the response cycle and captured so it holds afterwards.
    assign f_resp = tag_valid_reg && !tag_owner_reg;
    assign l_resp = tag_valid_reg && tag_owner_reg;

    always_comb begin
        f_rdata_next = f_rdata_reg;
        f_err_next   = f_err_reg;
        l_rdata_next = l_rdata_reg;
        l_err_next   = l_err_reg;
        if (f_resp) begin
            f_rdata_next = tag_err_reg ? RESET_NOP : m_rdata;
            f_err_next   = tag_err_reg;
        end
        if (l_resp) begin
            l_rdata_next = (tag_err_reg || tag_write_reg) ? 32'h0 : m_rdata;
            l_err_next   = tag_err_reg;
        end
    end

    assign f_rvalid = f_resp;
    assign f_rdata  = f_rdata_next;
    assign f_err    = f_err_next;
    assign l_rvalid = l_resp;
    assign l_rdata  = l_rdata_next;
    assign l_err    = l_err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= 4'd0;
            tag_valid_reg  <= 1'b0;
            tag_owner_reg  <= 1'b0;
            tag_err_reg    <= 1'b0;
            tag_write_reg  <= 1'b0;
            f_rdata_reg    <= 32'h0;
            f_err_reg      <= 1'b0;
            l_rdata_reg    <= 32'h0;
            l_err_reg      <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            tag_valid_reg  <= granted;
            tag_owner_reg  <= l_gnt;
            tag_err_reg    <= addr_err;
            tag_write_reg  <= l_gnt && l_we;
            f_rdata_reg    <= f_rdata_next;
            f_err_reg      <= f_err_next;
            l_rdata_reg    <= l_rdata_next;
            l_err_reg      <= l_err_next;
        end
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbiter and sequencer for the single-port instruction memory. Shares one synchronous word-addressed memory port between the CPU fetch requester and the program-loader requester. The loader has priority, but a starvation counter guarantees fetch forward progress. The block checks byte addresses for alignment and range, and routes each one-cycle-latency response back to the requester that issued it.

## Interface
- `DEPTH`, 256, memory depth in 32-bit words, power of two; `IDX_W = $clog2(DEPTH)`.
- `STARVE_MAX`, 4, consecutive lost conflicts after which fetch wins the next conflict (1..15).
- `RESET_NOP`, 32'h00000013, value driven on `f_rdata` on an error response.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  32  fetch byte address.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  fetch response valid.
- `f_rdata`  out  32  fetch read data.
- `f_err`  out  1  fetch response is an error.
- `l_req`  in  1  loader request.
- `l_we`  in  1  loader write (1) or read (0).
- `l_addr`  in  32  loader byte address.
- `l_wdata`  in  32  loader write data.
- `l_gnt`  out  1  loader request accepted.
- `l_rvalid`  out  1  loader response or write acknowledge.
- `l_rdata`  out  32  loader read data (0 for writes).
- `l_err`  out  1  loader response is an error.
- `m_en`  out  1  memory access enable.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  IDX_W  memory word index (`addr[IDX_W+1:2]`).
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory read data, valid the cycle after `m_en`.
- `l_lock`  in  1  loader exclusive lock (present only with `IMEM_ARB_LOCK_EN`).

## Operation
- Grants are combinational from the requests. At most one of `f_gnt`/`l_gnt` is high. A request retires at a rising edge where req&&gnt.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: loader wins, unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- `starve_cnt` (4 bit):
  - Increments on each cycle where both request and loader wins.
  - Clears on any `f_gnt`, or on any cycle with `f_req` = 0.
  - Saturates at `STARVE_MAX`.
- Address check on the granted request. Error if `addr[1:0] != 0`, or if `addr[31:IDX_W+2] != 0`. An erroring request is granted with `m_en` = 0.
- Memory drive for a granted, non-erroring request: `m_en` = 1, `m_we` = (loader && `l_we`), `m_addr` = word index, `m_wdata` = `l_wdata`. Memory outputs are 0 when no grant.
- Response tracking: one registered tag {valid, owner, err, write} records each retired request. The next cycle:
  - Owner's rvalid = 1.
  - Fetch read: `f_rdata` = `m_rdata`, or `RESET_NOP` on error.
  - Loader read: `l_rdata` = `m_rdata`, or 0 on error.
  - Loader write: `l_rdata` = 0.
  - err = tag err.
- `f_rdata`/`l_rdata`/err outputs are registered captures and hold their value until the owner's next response.

## Timing
- Throughput: one access per cycle. Back-to-back grants to either requester are allowed.
- Latency: rvalid exactly 1 cycle after the retiring edge, for reads, writes and errors alike.
- Requesters hold req/addr/we/wdata stable until granted. Dropping req before grant is legal (no access).
- Write-then-read to the same address on consecutive cycles returns the new data (memory is write-first).
- Reset values:
  - All rvalid/err outputs 0.
  - `f_rdata` = `l_rdata` = 0.
  - `starve_cnt` = 0, tag cleared.
  - Grants and `m_en` forced 0 while `rst_n` is low.
- Reset mid-operation: a pending response is discarded. No rvalid is produced after reset release for a pre-reset request.

## Configuration
- `IMEM_ARB_LOCK_EN` defined: the `l_lock` port exists. While `l_lock` = 1:
  - `f_gnt` = 0 regardless of `starve_cnt`.
  - `starve_cnt` is held at 0.
  - Loader requests are granted normally.
- Undefined: no `l_lock` port. Arbitration is as described in Operation.

## Test plan
- Reset: with `rst_n` low, `f_req` = `l_req` = 1. Required: all grants, `m_en`, rvalids = 0. After release, the first grant goes to the loader.
- Fetch only: `f_addr` 0x0, 0x4, 0x8 on consecutive cycles, memory preloaded with 0x11, 0x22, 0x33. Required: `f_gnt` = 1 each cycle; `f_rdata` = 0x11, 0x22, 0x33 one cycle later with `f_rvalid` = 1 and `f_err` = 0.
- Contention with `STARVE_MAX` = 4 and both requesting continuously. Required grant order: L,L,L,L,F,L,L,L,L,F.
- Loader write 0xDEADBEEF at 0x10, then fetch 0x10 on the next cycle. Required: `l_rvalid` = 1 with `l_rdata` = 0; then `f_rdata` = 0xDEADBEEF.
- Errors: fetch 0x2 → `f_err` = 1, `f_rdata` = 0x00000013, `m_en` = 0. Loader read 0x400 with `DEPTH` = 256 → `l_err` = 1, `l_rdata` = 0.
- Lock (with `IMEM_ARB_LOCK_EN`): `l_lock` = 1 and both requesting for 10 cycles → `f_gnt` = 0 throughout. Lock released → F granted within 5 cycles.
